hera_loader: RTL

Serial program loader for the HERA CPU. It receives an 8N1 UART stream on the COM line and checks a framed program image. It assembles bytes into 16-bit instruction words and writes them sequentially into the command memory through its write port. After a valid checksum it raises `run`, which releases the CPU from reset. It sits directly upstream of the command-memory write port and the CPU reset logic, in the role of the COM interface.

---
 rtl/hera_loader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/hera_loader.sv
// hera_loader: 8N1 UART program loader for the HERA command memory.
// Writes a framed image into memory word by word, and raises run once the checksum matches.
module hera_loader #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_s,
  input  logic              rxd,
  output logic [15:0]       data,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic              run,
  output logic              err
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [16:0]   CAP     = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DAT_H, DAT_L, CSUM, RUN} st_t;

  rx_t             rx_q, rx_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            byte_v_q, byte_v_d;
  logic            ferr_q, ferr_d;

  st_t               st_q, st_d;
  logic [15:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic [7:0]        lenh_q, lenh_d;
  logic [7:0]        cs_q, cs_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [16:0]       len_w;

  // RX front end: synchronizer, start validation at half bit, LSB-first sampling
  always_ff @(posedge clk) begin
    if (rst_s) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      rx_q     <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      byte_v_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= rxd;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      byte_v_q <= byte_v_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    rx_d     = rx_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_v_d = 1'b0;
    ferr_d   = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q && prev_q) rx_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Returning to idle at the stop sample lets a back-to-back start edge through.
        if (cnt_q == FULL_M1) begin
          rx_d     = RX_IDLE;
          byte_v_d = sync2_q;
          ferr_d   = !sync2_q;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Protocol stage: frame parsing, memory writes, checksum and run/err flags
  always_ff @(posedge clk) begin
    if (rst_s) begin
      st_q   <= IDLE;
      data_q <= '0;
      addr_q <= '0;
      wren_q <= 1'b0;
      run_q  <= 1'b0;
      err_q  <= 1'b0;
      lenh_q <= '0;
      cs_q   <= '0;
      wcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      addr_q <= addr_d;
      wren_q <= wren_d;
      run_q  <= run_d;
      err_q  <= err_d;
      lenh_q <= lenh_d;
      cs_q   <= cs_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign len_w = {1'b0, lenh_q, sh_q};

  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    addr_d = addr_q;
    wren_d = 1'b0;
    run_d  = run_q;
    err_d  = err_q;
    lenh_d = lenh_q;
    cs_d   = cs_q;
    wcnt_d = wcnt_q;
    if (wren_q) addr_d = addr_q + ADDR_W'(1);
    if (ferr_q) begin
      err_d = 1'b1;
      st_d  = IDLE;
    end else if (byte_v_q) begin
      case (st_q)
        IDLE, RUN: begin
          if (sh_q == 8'hA5) begin
            st_d   = LEN_H;
            run_d  = 1'b0;
            err_d  = 1'b0;
            addr_d = '0;
            cs_d   = '0;
          end
        end
        LEN_H: begin
          lenh_d = sh_q;
          cs_d   = cs_q ^ sh_q;
          st_d   = LEN_L;
        end
        LEN_L: begin
          cs_d = cs_q ^ sh_q;
          if (len_w == 17'd0 || len_w > CAP) begin
            err_d = 1'b1;
            st_d  = IDLE;
          end else begin
            wcnt_d = len_w[ADDR_W:0];
            st_d   = DAT_H;
          end
        end
        DAT_H: begin
          data_d[15:8] = sh_q;
          cs_d         = cs_q ^ sh_q;
          st_d         = DAT_L;
        end
        DAT_L: begin
          data_d[7:0] = sh_q;
          cs_d        = cs_q ^ sh_q;
          wren_d      = 1'b1;
          wcnt_d      = wcnt_q - (ADDR_W + 1)'(1);
          st_d        = (wcnt_q == (ADDR_W + 1)'(1)) ? CSUM : DAT_H;
        end
        CSUM: begin
          if (sh_q == cs_q) begin
            run_d = 1'b1;
            st_d  = RUN;
          end else begin
            err_d = 1'b1;
            st_d  = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  assign data = data_q;
  assign addr = addr_q;
  assign wren = wren_q;
  assign run  = run_q;
  assign err  = err_q;
endmodule
